// File: rtl/hdmi_cfg_sched.sv
// HDMI transmitter config scheduler: startup delay, debounced hot-plug, ten-entry ADV7511 init table, then single-client register writes.
// i2c_valid is registered (+1 cycle after INIT entry or write accept); one transaction in flight, held until i2c_ready; writes are not queued.
module hdmi_cfg_sched #(
  parameter int STARTUP_CYCLES = 50_000_000,
  parameter int HPD_DEBOUNCE   = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hpd,
  input  logic       wr_valid,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       i2c_valid,
  output logic [7:0] i2c_addr,
  output logic [7:0] i2c_data,
  input  logic       i2c_ready,
  output logic       cfg_done,
  output logic       busy
);

  localparam int DB_W = (HPD_DEBOUNCE > 1) ? $clog2(HPD_DEBOUNCE) : 1;
  localparam int SU_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(HPD_DEBOUNCE - 1);
  localparam logic [SU_W-1:0] SU_LAST  = SU_W'(STARTUP_CYCLES - 1);
  localparam logic [3:0]      LAST_IDX = 4'd9;

  typedef enum logic [1:0] {S_STARTUP, S_HPD_WAIT, S_INIT, S_RUN} state_t;

  state_t          state;
  logic [SU_W-1:0] su_cnt;
  logic [3:0]      idx;
  logic            hpd_s1, hpd_s2, hpd_db;
  logic [DB_W-1:0] db_cnt;
  logic            db_flip, hpd_up, hpd_fall;

  function automatic logic [15:0] init_entry(input logic [3:0] i);
    case (i)
      4'd0:    init_entry = 16'h9803;
      4'd1:    init_entry = 16'h9AE0;
      4'd2:    init_entry = 16'h9C30;
      4'd3:    init_entry = 16'h9D61;
      4'd4:    init_entry = 16'hA2A4;
      4'd5:    init_entry = 16'hA3A4;
      4'd6:    init_entry = 16'hE0D0;
      4'd7:    init_entry = 16'hF900;
      4'd8:    init_entry = 16'h1500;
      4'd9:    init_entry = 16'h1630;
      default: init_entry = 16'h0000;
    endcase
  endfunction

  // hpd_up is the level hpd_db takes at this edge, so a drop stops new
  // issues and clears cfg_done in the same cycle hpd_db falls.
  assign db_flip  = (hpd_s2 != hpd_db) && (db_cnt == DB_LAST);
  assign hpd_up   = db_flip ? hpd_s2 : hpd_db;
  assign hpd_fall = db_flip && hpd_db;
  assign busy     = i2c_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hpd_s1 <= 1'b0;
      hpd_s2 <= 1'b0;
      hpd_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      hpd_s1 <= hpd;
      hpd_s2 <= hpd_s1;
      if (hpd_s2 == hpd_db) begin
        db_cnt <= '0;
      end else if (db_flip) begin
        hpd_db <= hpd_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_STARTUP;
      su_cnt    <= '0;
      idx       <= '0;
      i2c_valid <= 1'b0;
      i2c_addr  <= 8'h00;
      i2c_data  <= 8'h00;
      wr_ready  <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      wr_ready <= 1'b0;
      if (hpd_fall) cfg_done <= 1'b0;
      case (state)
        S_STARTUP: begin
          if (su_cnt == SU_LAST) begin
            idx   <= '0;
            state <= hpd_db ? S_INIT : S_HPD_WAIT;
          end else begin
            su_cnt <= su_cnt + 1'b1;
          end
        end
        S_HPD_WAIT: begin
          if (hpd_db) begin
            idx   <= '0;
            state <= S_INIT;
          end
        end
        S_INIT: begin
          if (i2c_valid) begin
            if (i2c_ready) begin
              i2c_valid <= 1'b0;
              if (!hpd_up) begin
                state <= S_HPD_WAIT;
              end else if (idx == LAST_IDX) begin
                cfg_done <= 1'b1;
                state    <= S_RUN;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end else if (!hpd_up) begin
            state <= S_HPD_WAIT;
          end else begin
            i2c_valid            <= 1'b1;
            {i2c_addr, i2c_data} <= init_entry(idx);
          end
        end
        S_RUN: begin
          if (i2c_valid) begin
            if (i2c_ready) begin
              i2c_valid <= 1'b0;
              wr_ready  <= 1'b1;
              if (!hpd_up) state <= S_HPD_WAIT;
            end
          end else if (!hpd_up) begin
            state <= S_HPD_WAIT;
          end else if (wr_valid) begin
            i2c_valid <= 1'b1;
            i2c_addr  <= wr_addr;
            i2c_data  <= wr_data;
          end
        end
        default: state <= S_STARTUP;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_cfg_sched.sv
// Bench for hdmi_cfg_sched: expected transactions, wr_ready and cfg_done edges are derived
// from the table and cycle arithmetic (startup, debounce, 20-cycle i2c latency, 1-cycle gap).
module tb_hdmi_cfg_sched;
  localparam int S   = 100;
  localparam int D   = 8;
  localparam int LAT = 20;

  logic       clk;
  logic       reset_n;
  logic       hpd;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       i2c_valid;
  logic [7:0] i2c_addr;
  logic [7:0] i2c_data;
  logic       i2c_ready;
  logic       cfg_done;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int spur_req = 0;
  int log_base = 0;

  logic [15:0] tbl [10] = '{16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
                            16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1630};

  logic [7:0] obs_a[$], obs_d[$], exp_a[$], exp_d[$];
  int obs_s[$], obs_e[$], exp_s[$], exp_e[$];
  int wr_obs[$], wr_exp[$];
  int cfg_obs_c[$], cfg_obs_v[$], cfg_exp_c[$], cfg_exp_v[$];

  hdmi_cfg_sched #(.STARTUP_CYCLES(S), .HPD_DEBOUNCE(D)) dut (
    .clk(clk), .reset_n(reset_n), .hpd(hpd),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .i2c_valid(i2c_valid), .i2c_addr(i2c_addr), .i2c_data(i2c_data), .i2c_ready(i2c_ready),
    .cfg_done(cfg_done), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish before it", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // i2c_master stand-in: ready 20 cycles after valid rises, plus on-demand spurious pulses while idle
  initial begin : i2c_model
    int lat;
    int spur_done;
    lat = 0;
    spur_done = 0;
    i2c_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      i2c_ready = 1'b0;
      if (!reset_n || !i2c_valid) begin
        lat = 0;
        if (spur_req != spur_done && reset_n && !i2c_valid) begin
          spur_done = spur_req;
          i2c_ready = 1'b1;
        end
      end else begin
        lat++;
        if (lat == LAT) i2c_ready = 1'b1;
      end
    end
  end

  initial begin : monitor
    logic pv, pc;
    logic [7:0] ha, hd;
    pv = 1'b0; pc = 1'b0; ha = 8'h00; hd = 8'h00;
    forever begin
      @(posedge clk); #1;
      chk("busy_eq_valid", 32'(busy), 32'(i2c_valid));
      if (i2c_valid && !pv) begin
        obs_a.push_back(i2c_addr); obs_d.push_back(i2c_data);
        obs_s.push_back(cyc); obs_e.push_back(-1);
        ha = i2c_addr; hd = i2c_data;
      end else if (i2c_valid && pv) begin
        chk("hold_addr", 32'(i2c_addr), 32'(ha));
        chk("hold_data", 32'(i2c_data), 32'(hd));
      end
      if (!i2c_valid && pv) obs_e[obs_e.size()-1] = cyc;
      if (wr_ready) wr_obs.push_back(cyc);
      if (cfg_done !== pc) begin
        cfg_obs_c.push_back(cyc); cfg_obs_v.push_back(int'(cfg_done));
      end
      pv = i2c_valid; pc = cfg_done;
    end
  end

  task automatic expect_table(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(tbl[i][15:8]); exp_d.push_back(tbl[i][7:0]);
      exp_s.push_back(first + i * (LAT + 1)); exp_e.push_back(first + i * (LAT + 1) + LAT);
    end
  endtask

  task automatic expect_txn(input logic [7:0] a, input logic [7:0] d, input int st);
    exp_a.push_back(a); exp_d.push_back(d); exp_s.push_back(st); exp_e.push_back(st + LAT);
  endtask

  task automatic expect_cfg(input int c, input int v);
    cfg_exp_c.push_back(c); cfg_exp_v.push_back(v);
  endtask

  task automatic check_log(input string tag);
    int n_obs;
    n_obs = obs_a.size() - log_base;
    chk($sformatf("%s_count", tag), n_obs, exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      if (i < n_obs) begin
        chk($sformatf("%s_addr%0d", tag, i), 32'(obs_a[log_base+i]), 32'(exp_a[i]));
        chk($sformatf("%s_data%0d", tag, i), 32'(obs_d[log_base+i]), 32'(exp_d[i]));
        chk($sformatf("%s_start%0d", tag, i), obs_s[log_base+i], exp_s[i]);
        chk($sformatf("%s_end%0d", tag, i), obs_e[log_base+i], exp_e[i]);
      end
    end
    log_base = obs_a.size();
    exp_a.delete(); exp_d.delete(); exp_s.delete(); exp_e.delete();
  endtask

  task automatic wait_txns(input int n, input bit need_end, input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (obs_a.size() >= log_base + n) ok = !need_end || (obs_e[obs_e.size()-1] >= 0);
    end
    chk($sformatf("%s_reached", tag), 32'(ok), 32'd1);
  endtask

  task automatic wait_wr(input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = wr_ready;
    end
    chk($sformatf("%s_wr_ready_seen", tag), 32'(ok), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk($sformatf("%s_i2c_valid", tag), 32'(i2c_valid), 32'd0);
    chk($sformatf("%s_i2c_addr", tag), 32'(i2c_addr), 32'd0);
    chk($sformatf("%s_i2c_data", tag), 32'(i2c_data), 32'd0);
    chk($sformatf("%s_wr_ready", tag), 32'(wr_ready), 32'd0);
    chk($sformatf("%s_cfg_done", tag), 32'(cfg_done), 32'd0);
    chk($sformatf("%s_busy", tag), 32'(busy), 32'd0);
  endtask

  initial begin : stim
    int p, t0, k, n_wr;
    logic [7:0] a, d;
    reset_n = 1'b0; hpd = 1'b1; wr_valid = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset");

    // plugged from reset: table right after the startup delay, then cfg_done
    reset_n = 1'b1; p = cyc;
    expect_table(p + S + 1, 10);
    expect_cfg(p + S + 1 + 9 * (LAT + 1) + LAT, 1);
    wait_txns(10, 1'b1, 1500, "A");
    check_log("A");

    // stray i2c_ready while idle in RUN must do nothing
    spur_req++;
    repeat (4) @(negedge clk);
    chk("spur_no_txn", obs_a.size(), log_base);
    chk("spur_no_wr_ready", wr_obs.size(), wr_exp.size());

    // random runtime writes
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom); d = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      wr_valid = 1'b1; wr_addr = a; wr_data = d; t0 = cyc + 1;
      wait_wr(100, "A2");
      wr_valid = 1'b0;
      expect_txn(a, d, t0); wr_exp.push_back(t0 + LAT);
    end
    check_log("A2");

    // hpd drop during a runtime write; wr_valid dropped right after acceptance
    a = 8'($urandom); d = 8'($urandom);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; t0 = cyc + 1;
    @(negedge clk);
    wr_valid = 1'b0;
    k = $urandom_range(1, 5);
    repeat (k) @(negedge clk);
    hpd = 1'b0; p = cyc;
    expect_cfg(p + 2 + D, 0);
    wait_wr(100, "B");
    chk("B_cfg_done_at_wr_ready", 32'(cfg_done), 32'd0);
    expect_txn(a, d, t0); wr_exp.push_back(t0 + LAT);

    // unplugged with short glitches: no traffic
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(20, 60)) @(negedge clk);
      hpd = 1'b1;
      repeat (3) @(negedge clk);
      hpd = 1'b0;
    end
    repeat (320) @(negedge clk);
    check_log("B");

    // re-plug; a write held from the first table entry waits for RUN
    hpd = 1'b1; p = cyc; t0 = p + 4 + D;
    expect_table(t0, 10);
    expect_cfg(t0 + 9 * (LAT + 1) + LAT, 1);
    wait_txns(1, 1'b0, 100, "C_first");
    wr_valid = 1'b1; wr_addr = 8'h41; wr_data = 8'h10;
    wait_wr(400, "C");
    wr_valid = 1'b0;
    expect_txn(8'h41, 8'h10, t0 + 10 * (LAT + 1));
    wr_exp.push_back(t0 + 10 * (LAT + 1) + LAT);
    repeat (2) @(negedge clk);
    check_log("C");

    // unplug, re-plug, drop during entry 4
    hpd = 1'b0; p = cyc;
    expect_cfg(p + 2 + D, 0);
    repeat (50) @(negedge clk);
    hpd = 1'b1; p = cyc; t0 = p + 4 + D;
    expect_table(t0, 5);
    wait_txns(5, 1'b0, 300, "D_entry4");
    repeat ($urandom_range(1, 5)) @(negedge clk);
    hpd = 1'b0;
    repeat (150) @(negedge clk);
    chk("D_cfg_done_low", 32'(cfg_done), 32'd0);
    check_log("D");

    // replay from entry 0, reset during entry 7
    hpd = 1'b1; p = cyc; t0 = p + 4 + D;
    expect_table(t0, 8);
    wait_txns(8, 1'b0, 400, "E_entry7");
    repeat ($urandom_range(1, 10)) @(negedge clk);
    reset_n = 1'b0; p = cyc;
    exp_e[7] = p + 1;
    @(posedge clk); #1;
    check_zero("E_reset");
    @(negedge clk);
    check_log("E_pre");
    repeat (2) @(negedge clk);
    reset_n = 1'b1; p = cyc;
    expect_table(p + S + 1, 10);
    expect_cfg(p + S + 1 + 9 * (LAT + 1) + LAT, 1);
    wait_txns(10, 1'b1, 1500, "E");
    check_log("E");

    n_wr = wr_obs.size();
    chk("wr_ready_count", n_wr, wr_exp.size());
    for (int i = 0; i < wr_exp.size() && i < n_wr; i++)
      chk($sformatf("wr_ready_cycle%0d", i), wr_obs[i], wr_exp[i]);
    chk("cfg_edge_count", cfg_obs_c.size(), cfg_exp_c.size());
    for (int i = 0; i < cfg_exp_c.size() && i < cfg_obs_c.size(); i++) begin
      chk($sformatf("cfg_edge_cycle%0d", i), cfg_obs_c[i], cfg_exp_c[i]);
      chk($sformatf("cfg_edge_value%0d", i), cfg_obs_v[i], cfg_exp_v[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
